// File: rtl/ahb_lite_traffic_gen.sv
// AHB-Lite master issuing write / read-check / write-then-read SINGLE NONSEQ sequences.
// Latency: first address phase the cycle after start; N beats take N+1 cycles per pass with zero waits.
// Backpressure: HREADY=0 freezes all bus outputs and beat state; ERROR response aborts the run.
//
// Ports:
//   HCLK, HRESETn          bus clock, asynchronous active-low reset
//   start, mode            run request (sampled in IDLE only), 00 wr / 01 rd-check / 1x wr-then-rd
//   base_addr, word_cnt    first address (aligned internally), beats per pass (0 = no bus activity)
//   seed                   data pattern seed; beat data = seed ^ address
//   HADDR..HWDATA          AHB-Lite master outputs (SINGLE, unlocked, data/privileged access)
//   HREADY, HRDATA, HRESP  AHB-Lite slave response
//   busy, done             run in progress, one-cycle completion pulse
//   bus_err, err_cnt       ERROR seen / saturating read-mismatch count for the last run
//   first_err_addr         address of the first read mismatch of the last run (0 if none)
module ahb_lite_traffic_gen #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    word_cnt,
    input  logic [DATA_W-1:0]   seed,
    output logic [ADDR_W-1:0]   HADDR,
    output logic [2:0]          HBURST,
    output logic                HMASTLOCK,
    output logic [3:0]          HPROT,
    output logic [2:0]          HSIZE,
    output logic [1:0]          HTRANS,
    output logic                HWRITE,
    output logic [DATA_W-1:0]   HWDATA,
    input  logic                HREADY,
    input  logic [DATA_W-1:0]   HRDATA,
    input  logic                HRESP,
    output logic                busy,
    output logic                done,
    output logic                bus_err,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [ADDR_W-1:0]   first_err_addr
);

    localparam int BYTES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_GAP,
        S_RD,
        S_ERR,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                nonseq_q, nonseq_d;        // address phase currently presented
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic                hwrite_q, hwrite_d;
    logic [DATA_W-1:0]   hwdata_q, hwdata_d;
    logic [CNT_W-1:0]    issued_q, issued_d;        // address phases presented in this pass
    logic                dph_vld_q, dph_vld_d;      // a data phase is outstanding
    logic                dph_wr_q, dph_wr_d;
    logic [ADDR_W-1:0]   dph_addr_q, dph_addr_d;
    logic                wtr_q, wtr_d;              // write pass followed by a read pass
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic                bus_err_q, bus_err_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   first_err_q, first_err_d;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] s);
        return s ^ DATA_W'(a);
    endfunction

    always_comb begin
        state_d     = state_q;
        nonseq_d    = nonseq_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        issued_d    = issued_q;
        dph_vld_d   = dph_vld_q;
        dph_wr_d    = dph_wr_q;
        dph_addr_d  = dph_addr_q;
        wtr_d       = wtr_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        seed_d      = seed_q;
        bus_err_d   = bus_err_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wtr_d       = mode[1];
                    base_d      = base_addr & ALIGN_MASK;
                    cnt_d       = word_cnt;
                    seed_d      = seed;
                    bus_err_d   = 1'b0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    if (word_cnt == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = (mode == 2'b01) ? S_RD : S_WR;
                        nonseq_d = 1'b1;
                        haddr_d  = base_addr & ALIGN_MASK;
                        hwrite_d = (mode != 2'b01);
                        issued_d = CNT_W'(1);
                    end
                end
            end

            S_WR, S_RD: begin
                if (dph_vld_q && HRESP && !HREADY) begin
                    // First ERROR cycle: withdraw the pending address phase before
                    // the slave can accept it in the second ERROR cycle.
                    nonseq_d  = 1'b0;
                    hwrite_d  = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = S_ERR;
                end else if (HREADY) begin
                    if (dph_vld_q && !dph_wr_q &&
                        (HRDATA != pattern(dph_addr_q, seed_q))) begin
                        // err_cnt still zero means this is the first mismatch of the run
                        if (err_cnt_q == '0) begin
                            first_err_d = dph_addr_q;
                        end
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                    end
                    if (nonseq_q) begin
                        dph_vld_d  = 1'b1;
                        dph_wr_d   = hwrite_q;
                        dph_addr_d = haddr_q;
                        if (hwrite_q) begin
                            hwdata_d = pattern(haddr_q, seed_q);
                        end
                        if (issued_q < cnt_q) begin
                            haddr_d  = haddr_q + ADDR_STEP;
                            issued_d = issued_q + CNT_W'(1);
                        end else begin
                            nonseq_d = 1'b0;
                            hwrite_d = 1'b0;
                        end
                    end else begin
                        // No address phase left: the final data phase just completed.
                        dph_vld_d = 1'b0;
                        state_d   = (state_q == S_WR && wtr_q) ? S_GAP : S_DONE;
                    end
                end
            end

            S_GAP: begin
                state_d  = S_RD;
                nonseq_d = 1'b1;
                hwrite_d = 1'b0;
                haddr_d  = base_q;
                issued_d = CNT_W'(1);
            end

            S_ERR: begin
                if (HREADY) begin
                    dph_vld_d = 1'b0;
                    state_d   = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            nonseq_q    <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            issued_q    <= '0;
            dph_vld_q   <= 1'b0;
            dph_wr_q    <= 1'b0;
            dph_addr_q  <= '0;
            wtr_q       <= 1'b0;
            base_q      <= '0;
            cnt_q       <= '0;
            seed_q      <= '0;
            bus_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            nonseq_q    <= nonseq_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            issued_q    <= issued_d;
            dph_vld_q   <= dph_vld_d;
            dph_wr_q    <= dph_wr_d;
            dph_addr_q  <= dph_addr_d;
            wtr_q       <= wtr_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            bus_err_q   <= bus_err_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    assign HADDR          = haddr_q;
    assign HBURST         = 3'b000;
    assign HMASTLOCK      = 1'b0;
    assign HPROT          = 4'b0011;
    assign HSIZE          = (DATA_W == 64) ? 3'b011 : 3'b010;
    assign HTRANS         = nonseq_q ? 2'b10 : 2'b00;
    assign HWRITE         = hwrite_q;
    assign HWDATA         = hwdata_q;
    assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done           = (state_q == S_DONE);
    assign bus_err        = bus_err_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_ahb_lite_traffic_gen.sv
// Bench for ahb_lite_traffic_gen: behavioural AHB-Lite memory slave with wait/error injection,
// plus a transfer-list reference model built from the address/data pattern rules.
module tb_ahb_lite_traffic_gen;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] base_addr;
    logic [15:0] word_cnt;
    logic [31:0] seed;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA = 32'h0;
    logic        HRESP  = 1'b0;
    logic        busy;
    logic        done;
    logic        bus_err;
    logic [15:0] err_cnt;
    logic [31:0] first_err_addr;

    always #5 HCLK = ~HCLK;

    ahb_lite_traffic_gen #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mode(mode),
        .base_addr(base_addr), .word_cnt(word_cnt), .seed(seed),
        .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP),
        .busy(busy), .done(done), .bus_err(bus_err), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr)
    );

    int vectors = 0;
    int miscompares = 0;

    // slave memory and configuration (configuration written by the stimulus block only)
    logic [31:0] mem [logic [31:0]];
    int          cfg_waits = 0;       // <0: random 0..2 per beat
    int          cfg_err_abs = -1;    // absolute beat number that gets an ERROR response
    int          corrupt_tok = 0;
    logic [31:0] corrupt_addr = 32'h0;
    logic [31:0] corrupt_mask = 32'h0;

    // slave-owned state and logs
    int          seen_tok = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] log_a[$];
    logic        log_w[$];
    logic [31:0] log_d[$];
    logic        dp_vld = 1'b0, dp_wr = 1'b0, err_stage = 1'b0, prev_wait = 1'b0;
    logic        s_hr, s_rsp, s_wait;
    logic [31:0] dp_addr = 32'h0;
    int          dp_beat = 0, wait_left = 0;
    logic [31:0] prev_haddr, prev_hwdata;
    logic [1:0]  prev_htrans;

    // reference model expectations for the current run
    logic [31:0] exp_a[$];
    logic        exp_w[$];
    logic [31:0] exp_d[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(negedge HCLK) begin
        if (done === 1'b1) done_cnt++;
    end

    // AHB-Lite slave: decides HREADY/HRESP for the current cycle half a cycle before the edge
    always @(negedge HCLK) begin
        if (corrupt_tok != seen_tok) begin
            mem[corrupt_addr] = rd(corrupt_addr) ^ corrupt_mask;
            seen_tok = corrupt_tok;
        end
        if (!HRESETn) begin
            dp_vld = 1'b0; err_stage = 1'b0; prev_wait = 1'b0;
            HREADY = 1'b1; HRESP = 1'b0;
        end else begin
            if (prev_wait) begin
                check("hold_haddr", 64'(HADDR), 64'(prev_haddr));
                check("hold_htrans", 64'(HTRANS), 64'(prev_htrans));
                check("hold_hwdata", 64'(HWDATA), 64'(prev_hwdata));
            end
            s_hr = 1'b1; s_rsp = 1'b0; s_wait = 1'b0;
            if (dp_vld) begin
                if (err_stage) begin
                    check("err2_htrans_idle", 64'(HTRANS), 64'(2'b00));
                    s_rsp = 1'b1;
                    err_stage = 1'b0;
                end else if (dp_beat == cfg_err_abs) begin
                    s_hr = 1'b0; s_rsp = 1'b1; err_stage = 1'b1;
                end else if (wait_left > 0) begin
                    s_hr = 1'b0; s_wait = 1'b1; wait_left--;
                end else begin
                    if (dp_wr) mem[dp_addr] = HWDATA;
                    else HRDATA = rd(dp_addr);
                    log_a.push_back(dp_addr);
                    log_w.push_back(dp_wr);
                    log_d.push_back(dp_wr ? HWDATA : HRDATA);
                end
            end
            HREADY = s_hr; HRESP = s_rsp; prev_wait = s_wait;
            if (s_hr) begin
                dp_vld = 1'b0;
                if (HTRANS == 2'b10) begin
                    acc_cnt++;
                    dp_vld = 1'b1; dp_addr = HADDR; dp_wr = HWRITE; dp_beat = acc_cnt;
                    wait_left = (cfg_waits < 0) ? int'($urandom_range(0, 2)) : cfg_waits;
                end
            end
            prev_haddr = HADDR; prev_htrans = HTRANS; prev_hwdata = HWDATA;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_htrans"}, 64'(HTRANS), 64'(0));
        check({tag, "_haddr"}, 64'(HADDR), 64'(0));
        check({tag, "_hwdata"}, 64'(HWDATA), 64'(0));
        check({tag, "_hwrite"}, 64'(HWRITE), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_bus_err"}, 64'(bus_err), 64'(0));
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'(0));
        check({tag, "_first_err"}, 64'(first_err_addr), 64'(0));
    endtask

    task automatic corrupt(input logic [31:0] a, input logic [31:0] m);
        corrupt_addr = a; corrupt_mask = m; corrupt_tok++;
        @(negedge HCLK);
        @(negedge HCLK);
    endtask

    // One run: build the expected transfer list, start the DUT, wait for done, compare.
    task automatic run(input logic [1:0] m, input logic [31:0] b, input int n,
                       input logic [31:0] s, input int waits, input int errb, output int lat);
        logic [31:0] a0, a, ef;
        int ee, total, ncomp, eacc, acc0, log0, done0;
        exp_a.delete(); exp_w.delete(); exp_d.delete();
        a0 = b & 32'hFFFF_FFFC;
        if (m != 2'b01)
            for (int i = 0; i < n; i++) begin
                a = a0 + 32'(4 * i);
                exp_a.push_back(a); exp_w.push_back(1'b1); exp_d.push_back(s ^ a);
            end
        if (m != 2'b00)
            for (int i = 0; i < n; i++) begin
                a = a0 + 32'(4 * i);
                exp_a.push_back(a); exp_w.push_back(1'b0); exp_d.push_back(s ^ a);
            end
        total = exp_a.size();
        if (errb > 0 && errb <= total) begin ncomp = errb - 1; eacc = errb; end
        else begin ncomp = total; eacc = total; end
        // read-check only sees memory as it stood before the run; written words always match
        ee = 0; ef = 32'h0;
        for (int j = 0; j < ncomp; j++)
            if (m == 2'b01 && rd(exp_a[j]) != exp_d[j]) begin
                if (ee == 0) ef = exp_a[j];
                ee++;
            end
        acc0 = acc_cnt; log0 = log_a.size(); done0 = done_cnt;
        cfg_waits = waits;
        cfg_err_abs = (errb > 0) ? acc0 + errb : -1;
        @(negedge HCLK);
        start = 1'b1; mode = m; base_addr = b; word_cnt = 16'(n); seed = s;
        @(negedge HCLK);
        start = 1'b0; mode = 2'($urandom); base_addr = $urandom;
        word_cnt = 16'($urandom); seed = $urandom;
        check("busy_after_start", 64'(busy), 64'(n != 0));
        lat = 1;
        while (done !== 1'b1 && lat < 3000) begin
            @(negedge HCLK);
            lat++;
        end
        check("done_seen", 64'(done), 64'(1));
        check("busy_in_done", 64'(busy), 64'(0));
        repeat (4) @(negedge HCLK);
        check("done_pulses", 64'(done_cnt - done0), 64'(1));
        check("busy_after", 64'(busy), 64'(0));
        check("addr_phases", 64'(acc_cnt - acc0), 64'(eacc));
        check("xfers", 64'(log_a.size() - log0), 64'(ncomp));
        for (int j = 0; j < ncomp && log0 + j < log_a.size(); j++) begin
            check("xfer_addr", 64'(log_a[log0 + j]), 64'(exp_a[j]));
            check("xfer_write", 64'(log_w[log0 + j]), 64'(exp_w[j]));
            if (exp_w[j]) check("xfer_wdata", 64'(log_d[log0 + j]), 64'(exp_d[j]));
        end
        check("err_cnt", 64'(err_cnt), 64'(ee));
        check("first_err_addr", 64'(first_err_addr), 64'(ef));
        check("bus_err", 64'(bus_err), 64'(errb > 0 && errb <= total));
        cfg_err_abs = -1;
    endtask

    initial begin
        int lat, n, acc0;
        logic [31:0] b, s;
        HRESETn = 1'b0; start = 1'b0; mode = 2'b00; base_addr = 32'h0;
        word_cnt = 16'h0; seed = 32'h0;
        repeat (2) @(negedge HCLK);
        check_reset("rst");
        check("hburst", 64'(HBURST), 64'(3'b000));
        check("hmastlock", 64'(HMASTLOCK), 64'(0));
        check("hprot", 64'(HPROT), 64'(4'b0011));
        check("hsize", 64'(HSIZE), 64'(3'b010));
        HRESETn = 1'b1;
        @(negedge HCLK);

        // plain write burst, zero-wait slave
        run(2'b00, 32'h10, 4, 32'hAA5555AA, 0, 0, lat);
        check("t1_latency", 64'(lat), 64'(6));
        check("t1_data0", 64'(log_d[0]), 64'(32'hAA5555BA));
        check("t1_data1", 64'(log_d[1]), 64'(32'hAA5555BE));
        check("t1_data2", 64'(log_d[2]), 64'(32'hAA5555B2));
        check("t1_data3", 64'(log_d[3]), 64'(32'hAA5555B6));

        // write then read back
        run(2'b10, 32'h10, 4, 32'hAA5555AA, 0, 0, lat);

        // read-check with one corrupted word
        corrupt(32'h18, 32'h0000_0100);
        run(2'b01, 32'h10, 4, 32'hAA5555AA, 0, 0, lat);
        check("t3_err_cnt", 64'(err_cnt), 64'(1));
        check("t3_first_err", 64'(first_err_addr), 64'(32'h18));

        // three wait states per beat
        run(2'b10, 32'h100, 4, 32'h1234_5678, 3, 0, lat);

        // ERROR on beat 2 of 4
        run(2'b00, 32'h200, 4, 32'hCAFE_F00D, 1, 2, lat);
        check("t5_bus_err", 64'(bus_err), 64'(1));

        // unaligned base near the top of the address space, mode 11
        run(2'b11, 32'hFFFF_FFFA, 4, 32'h0F0F_0F0F, 0, 0, lat);

        // randomized write / corrupt / read-check passes
        for (int k = 0; k < 5; k++) begin
            b = $urandom; s = $urandom; n = int'($urandom_range(1, 6));
            run((k % 2 != 0) ? 2'b10 : 2'b00, b, n, s, -1, 0, lat);
            repeat (int'($urandom_range(0, 2)))
                corrupt((b & 32'hFFFF_FFFC) + 32'(4 * $urandom_range(0, n - 1)),
                        32'h1 << $urandom_range(0, 31));
            run(2'b01, b, n, s, -1, 0, lat);
        end
        run(2'($urandom), $urandom, int'($urandom_range(0, 5)), $urandom, -1, 0, lat);
        n = int'($urandom_range(1, 6));
        run(2'b00, $urandom, n, $urandom, -1, int'($urandom_range(1, n)), lat);

        // reset in the middle of a read pass, then an empty run
        cfg_waits = 0;
        @(negedge HCLK);
        start = 1'b1; mode = 2'b01; base_addr = 32'h10; word_cnt = 16'd8; seed = 32'h5;
        @(negedge HCLK);
        start = 1'b0;
        repeat (3) @(negedge HCLK);
        check("t6_busy_before_rst", 64'(busy), 64'(1));
        HRESETn = 1'b0;
        #1;
        check_reset("rst_mid");
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        acc0 = acc_cnt;
        repeat (4) @(negedge HCLK);
        check("t6_no_resume", 64'(acc_cnt - acc0), 64'(0));
        check("t6_htrans_idle", 64'(HTRANS), 64'(0));
        run(2'b10, 32'h40, 0, 32'h77, 0, 0, lat);
        check("t6_cnt0_latency", 64'(lat), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
